// File: rtl/cu_wb_sched.sv
// Issue/writeback scheduler: tracks in-flight results of fixed-latency units,
// rejects hazardous issues, and drives the single regfile writeback port.
module cu_wb_sched #(
   parameter int                     ADDRESS_WIDTH = 4,
   parameter int                     NUM_UNITS     = 3,
   parameter logic [4*NUM_UNITS-1:0] UNIT_LAT      = {4'd3, 4'd1, 4'd1},
   parameter int                     MAX_LAT       = 8,
   localparam int                    UW            = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                     clk_exe,
   input  logic                     reset,
   input  logic                     stallb,
   input  logic                     ps_iss_vld,
   input  logic [UW-1:0]            ps_iss_unit,
   input  logic [ADDRESS_WIDTH-1:0] ps_iss_wadd,
   input  logic [ADDRESS_WIDTH-1:0] ps_iss_raddx,
   input  logic [ADDRESS_WIDTH-1:0] ps_iss_raddy,
   input  logic                     ps_iss_rx_en,
   input  logic                     ps_iss_ry_en,
   output logic                     iss_ps_acc,
   output logic [1:0]               iss_ps_cause,
   output logic                     sb_xb_w_en,
   output logic [ADDRESS_WIDTH-1:0] sb_xb_wadd,
   output logic [NUM_UNITS-1:0]     sb_xb_w_cuEn,
   output logic                     sb_ps_busy
);

   // Entry 0 is the writeback register; entry k reaches it k edges later.
   // An issue of latency L lands in entry L-1 so it is written back in cycle t+L.
   logic [MAX_LAT-1:0]       valid_q, valid_d;
   logic [UW-1:0]            unit_q [MAX_LAT];
   logic [UW-1:0]            unit_d [MAX_LAT];
   logic [ADDRESS_WIDTH-1:0] wadd_q [MAX_LAT];
   logic [ADDRESS_WIDTH-1:0] wadd_d [MAX_LAT];

   logic [3:0] issLat;
   logic       legalUnit;
   logic       rawHit;
   logic       wawHit;
   logic       structHit;
   logic [1:0] causeS;
   logic       accS;

   always_comb begin
      issLat    = 4'd0;
      legalUnit = 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (ps_iss_unit == UW'(u)) begin
            issLat    = UNIT_LAT[4*u +: 4];
            legalUnit = 1'b1;
         end
      end
   end

   // Entries still in the table after this edge are pending; the writeback register never blocks.
   always_comb begin
      rawHit    = 1'b0;
      wawHit    = 1'b0;
      structHit = !legalUnit;
      for (int k = 1; k < MAX_LAT; k++) begin
         if (valid_q[k]) begin
            if ((ps_iss_rx_en && (ps_iss_raddx == wadd_q[k])) ||
                (ps_iss_ry_en && (ps_iss_raddy == wadd_q[k]))) begin
               rawHit = 1'b1;
            end
            if (ps_iss_wadd == wadd_q[k]) begin
               wawHit = 1'b1;
            end
            if (int'(issLat) == k) begin
               structHit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      causeS = 2'b00;
      if (ps_iss_vld && stallb && reset) begin
         if (rawHit) begin
            causeS = 2'b01;
         end else if (wawHit) begin
            causeS = 2'b10;
         end else if (structHit) begin
            causeS = 2'b11;
         end
      end
      accS = ps_iss_vld && stallb && reset && (causeS == 2'b00);
   end

   assign iss_ps_acc   = accS;
   assign iss_ps_cause = causeS;

   always_comb begin
      valid_d = valid_q;
      unit_d  = unit_q;
      wadd_d  = wadd_q;
      if (stallb) begin
         for (int k = 0; k < MAX_LAT - 1; k++) begin
            valid_d[k] = valid_q[k+1];
            unit_d[k]  = unit_q[k+1];
            wadd_d[k]  = wadd_q[k+1];
         end
         valid_d[MAX_LAT-1] = 1'b0;
         unit_d[MAX_LAT-1]  = '0;
         wadd_d[MAX_LAT-1]  = '0;
         for (int k = 0; k < MAX_LAT; k++) begin
            if (accS && (int'(issLat) == k + 1)) begin
               valid_d[k] = 1'b1;
               unit_d[k]  = ps_iss_unit;
               wadd_d[k]  = ps_iss_wadd;
            end
         end
      end
   end

   always_ff @(posedge clk_exe) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 0; k < MAX_LAT; k++) begin
            unit_q[k] <= '0;
            wadd_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         unit_q  <= unit_d;
         wadd_q  <= wadd_d;
      end
   end

   always_comb begin
      sb_xb_w_cuEn = '0;
      if (valid_q[0]) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_q[0] == UW'(u)) begin
               sb_xb_w_cuEn[u] = 1'b1;
            end
         end
      end
   end

   assign sb_xb_w_en = valid_q[0] & stallb;
   assign sb_xb_wadd = wadd_q[0];
   assign sb_ps_busy = |valid_q;

endmodule

// File: tb/tb_cu_wb_sched.sv
// Directed testbench for cu_wb_sched: reset, single issue, RAW/WAW/structural
// hazards, stalls and mid-flight reset, with hand-computed expectations.
module tb_cu_wb_sched;

   logic       clk_exe = 1'b0;
   logic       reset;
   logic       stallb;
   logic       ps_iss_vld;
   logic [1:0] ps_iss_unit;
   logic [3:0] ps_iss_wadd;
   logic [3:0] ps_iss_raddx;
   logic [3:0] ps_iss_raddy;
   logic       ps_iss_rx_en;
   logic       ps_iss_ry_en;
   logic       iss_ps_acc;
   logic [1:0] iss_ps_cause;
   logic       sb_xb_w_en;
   logic [3:0] sb_xb_wadd;
   logic [2:0] sb_xb_w_cuEn;
   logic       sb_ps_busy;

   int checks = 0;
   int errors = 0;

   cu_wb_sched dut (
      .clk_exe      (clk_exe),
      .reset        (reset),
      .stallb       (stallb),
      .ps_iss_vld   (ps_iss_vld),
      .ps_iss_unit  (ps_iss_unit),
      .ps_iss_wadd  (ps_iss_wadd),
      .ps_iss_raddx (ps_iss_raddx),
      .ps_iss_raddy (ps_iss_raddy),
      .ps_iss_rx_en (ps_iss_rx_en),
      .ps_iss_ry_en (ps_iss_ry_en),
      .iss_ps_acc   (iss_ps_acc),
      .iss_ps_cause (iss_ps_cause),
      .sb_xb_w_en   (sb_xb_w_en),
      .sb_xb_wadd   (sb_xb_wadd),
      .sb_xb_w_cuEn (sb_xb_w_cuEn),
      .sb_ps_busy   (sb_ps_busy)
   );

   always #5 clk_exe = ~clk_exe;

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic applyStimulus(input logic vld, input logic [1:0] unit, input logic [3:0] wadd,
                                input logic [3:0] rx, input logic rxEn,
                                input logic [3:0] ry, input logic ryEn);
      ps_iss_vld   = vld;
      ps_iss_unit  = unit;
      ps_iss_wadd  = wadd;
      ps_iss_raddx = rx;
      ps_iss_rx_en = rxEn;
      ps_iss_raddy = ry;
      ps_iss_ry_en = ryEn;
      #2;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic nextCycle();
      @(posedge clk_exe);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkIss(input string tag, input logic acc, input logic [1:0] cause);
      checkOutput({tag, ".acc"}, 32'(iss_ps_acc), 32'(acc));
      checkOutput({tag, ".cause"}, 32'(iss_ps_cause), 32'(cause));
   endtask

   task automatic checkWb(input string tag, input logic en, input logic [3:0] wadd,
                          input logic [2:0] cuEn, input logic busy);
      checkOutput({tag, ".w_en"}, 32'(sb_xb_w_en), 32'(en));
      if (en) begin
         checkOutput({tag, ".wadd"}, 32'(sb_xb_wadd), 32'(wadd));
      end
      checkOutput({tag, ".cuEn"}, 32'(sb_xb_w_cuEn), 32'(cuEn));
      checkOutput({tag, ".busy"}, 32'(sb_ps_busy), 32'(busy));
   endtask

   initial begin
      // Reset held for two cycles with an issue request present
      reset  = 1'b0;
      stallb = 1'b1;
      applyStimulus(1'b1, 2'd0, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("rst1", 1'b0, 2'b00);
      checkWb("rst1", 1'b0, 4'd0, 3'b000, 1'b0);
      checkOutput("rst1.wadd0", 32'(sb_xb_wadd), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("rst2", 1'b0, 2'b00);
      checkWb("rst2", 1'b0, 4'd0, 3'b000, 1'b0);
      nextCycle();
      reset = 1'b1;
      idle();
      checkIss("post_rst_idle", 1'b0, 2'b00);
      checkWb("post_rst0", 1'b0, 4'd0, 3'b000, 1'b0);
      nextCycle();
      idle();
      checkWb("post_rst1", 1'b0, 4'd0, 3'b000, 1'b0);

      // Single ALU issue: writeback exactly one cycle later
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("alu_iss", 1'b1, 2'b00);
      checkWb("alu_t", 1'b0, 4'd0, 3'b000, 1'b0);
      nextCycle();
      idle();
      checkWb("alu_t1", 1'b1, 4'd5, 3'b001, 1'b1);
      nextCycle();
      idle();
      checkWb("alu_t2", 1'b0, 4'd0, 3'b000, 1'b0);

      // RAW: ALU reading r7 waits for the MUL producing r7
      nextCycle();
      applyStimulus(1'b1, 2'd2, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("raw_mul", 1'b1, 2'b00);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd1, 4'd7, 1'b1, 4'd0, 1'b0);
      checkIss("raw_t1", 1'b0, 2'b01);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd1, 4'd7, 1'b1, 4'd0, 1'b0);
      checkIss("raw_t2", 1'b0, 2'b01);
      checkWb("raw_t2", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd1, 4'd7, 1'b1, 4'd0, 1'b0);
      checkIss("raw_t3", 1'b1, 2'b00);
      checkWb("raw_t3", 1'b1, 4'd7, 3'b100, 1'b1);
      nextCycle();
      idle();
      checkWb("raw_t4", 1'b1, 4'd1, 3'b001, 1'b1);
      nextCycle();
      idle();
      checkWb("raw_t5", 1'b0, 4'd0, 3'b000, 1'b0);

      // WAW, then RAW+WAW+structural together resolves to RAW
      nextCycle();
      applyStimulus(1'b1, 2'd2, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("waw_mul", 1'b1, 2'b00);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("waw_t1", 1'b0, 2'b10);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd3, 4'd0, 1'b0, 4'd3, 1'b1);
      checkIss("prio_t2", 1'b0, 2'b01);
      nextCycle();
      idle();
      checkWb("waw_t3", 1'b1, 4'd3, 3'b100, 1'b1);
      nextCycle();
      idle();
      checkWb("waw_t4", 1'b0, 4'd0, 3'b000, 1'b0);

      // Structural: shifter result would collide with the MUL writeback
      nextCycle();
      applyStimulus(1'b1, 2'd2, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("st_mul", 1'b1, 2'b00);
      nextCycle();
      idle();
      nextCycle();
      applyStimulus(1'b1, 2'd1, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("st_t2", 1'b0, 2'b11);
      checkWb("st_t2", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 2'd1, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("st_t3", 1'b1, 2'b00);
      checkWb("st_t3", 1'b1, 4'd2, 3'b100, 1'b1);
      nextCycle();
      idle();
      checkWb("st_t4", 1'b1, 4'd9, 3'b010, 1'b1);
      nextCycle();
      idle();
      checkWb("st_t5", 1'b0, 4'd0, 3'b000, 1'b0);

      // Illegal unit index is rejected and leaves nothing in flight
      nextCycle();
      applyStimulus(1'b1, 2'd3, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("bad_unit", 1'b0, 2'b11);
      nextCycle();
      idle();
      checkWb("bad_unit_after", 1'b0, 4'd0, 3'b000, 1'b0);

      // Back-to-back same-latency issues both accepted
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("b2b_0", 1'b1, 2'b00);
      nextCycle();
      applyStimulus(1'b1, 2'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("b2b_1", 1'b1, 2'b00);
      checkWb("b2b_1", 1'b1, 4'd1, 3'b001, 1'b1);
      nextCycle();
      idle();
      checkWb("b2b_2", 1'b1, 4'd2, 3'b010, 1'b1);

      // Stall while a MUL is in flight delays its writeback by two cycles
      nextCycle();
      applyStimulus(1'b1, 2'd2, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("stall_mul", 1'b1, 2'b00);
      nextCycle();
      stallb = 1'b0;
      applyStimulus(1'b1, 2'd0, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("stall_t1", 1'b0, 2'b00);
      checkWb("stall_t1", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("stall_t2", 1'b0, 2'b00);
      checkWb("stall_t2", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      stallb = 1'b1;
      idle();
      checkWb("stall_t3", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      idle();
      checkWb("stall_t4", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      idle();
      checkWb("stall_t5", 1'b1, 4'd4, 3'b100, 1'b1);
      nextCycle();
      idle();
      checkWb("stall_t6", 1'b0, 4'd0, 3'b000, 1'b0);

      // Stall while the result sits on the writeback port: presented once on release
      nextCycle();
      applyStimulus(1'b1, 2'd0, 4'd10, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("wbstall_iss", 1'b1, 2'b00);
      nextCycle();
      stallb = 1'b0;
      idle();
      checkWb("wbstall_t1", 1'b0, 4'd0, 3'b001, 1'b1);
      checkOutput("wbstall_t1.wadd", 32'(sb_xb_wadd), 32'd10);
      nextCycle();
      stallb = 1'b1;
      idle();
      checkWb("wbstall_t2", 1'b1, 4'd10, 3'b001, 1'b1);
      nextCycle();
      idle();
      checkWb("wbstall_t3", 1'b0, 4'd0, 3'b000, 1'b0);

      // Reset mid-flight discards the MUL result
      nextCycle();
      applyStimulus(1'b1, 2'd2, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("mrst_mul", 1'b1, 2'b00);
      nextCycle();
      reset = 1'b0;
      applyStimulus(1'b1, 2'd0, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0);
      checkIss("mrst_t1", 1'b0, 2'b00);
      checkWb("mrst_t1", 1'b0, 4'd0, 3'b000, 1'b1);
      nextCycle();
      reset = 1'b1;
      idle();
      checkWb("mrst_t2", 1'b0, 4'd0, 3'b000, 1'b0);
      nextCycle();
      idle();
      checkWb("mrst_t3", 1'b0, 4'd0, 3'b000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
